// File: rtl/vram_text_reader.sv
// ----------------------------------------------------------------------------
// vram_text_reader
//
// Read-side consumer of the character video RAM. It turns the VGA scan
// position into a video RAM read address, then a font ROM address, then a
// 24-bit RGB pixel. The pipeline has a fixed 5-cycle latency and is matched
// to single-cycle synchronous RAM/ROM read ports. It also provides a splash
// screen glyph source and a blinking cell cursor.
//
// Ports:
//   clk         pixel clock, one pixel per cycle
//   rst         synchronous active-high reset
//   h_addr      scan column from the VGA controller
//   v_addr      scan row from the VGA controller
//   de          display enable from the VGA controller
//   splash      1 = glyphs from splash_q, 0 = glyphs from vram_q
//   vram_addr   video RAM read address (row*COLS + col)
//   vram_q      video RAM data: [10:8] colour code, [7:0] character code
//   splash_q    splash ROM data for the same address as vram_addr
//   font_addr   font ROM address {glyph, line}
//   font_q      font ROM row, bit k = pixel column k of the cell (bit 0 left)
//   cursor_en   enables the cursor overlay
//   cursor_pos  linear cell index of the cursor
//   vga_data    RGB pixel out
//   pix_valid   de delayed to line up with vga_data
// ----------------------------------------------------------------------------
module vram_text_reader #(
    parameter int COLS         = 70,
    parameter int ROWS         = 30,
    parameter int CELL_W       = 9,
    parameter int CELL_H       = 16,
    parameter int ACTIVE_W     = 630,
    parameter int BLINK_CYCLES = 12500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  h_addr,
    input  logic [9:0]  v_addr,
    input  logic        de,
    input  logic        splash,
    output logic [11:0] vram_addr,
    input  logic [10:0] vram_q,
    input  logic [7:0]  splash_q,
    output logic [11:0] font_addr,
    input  logic [11:0] font_q,
    input  logic        cursor_en,
    input  logic [11:0] cursor_pos,
    output logic [23:0] vga_data,
    output logic        pix_valid
);

    localparam int         LINE_W  = $clog2(CELL_H);
    localparam int         BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [3:0] PX_LAST = 4'(CELL_W - 1);
    localparam logic [9:0] V_LIMIT = 10'(ROWS * CELL_H);

    // Column tracker state: previous h_addr and the px/col of that position
    logic [9:0]         last_h_q,      last_h_d;
    logic               track_ok_q,    track_ok_d;
    logic [6:0]         col_q,         col_d;
    logic [3:0]         px1_q,         px1_d;

    // Stage 1: cell position and RAM address
    logic [3:0]         line1_q,       line1_d;
    logic               vis1_q,        vis1_d;
    logic               de1_q,         de1_d;
    logic [11:0]        vram_addr_q,   vram_addr_d;

    // Stage 2: waiting on the video RAM read
    logic [3:0]         px2_q,         px2_d;
    logic [3:0]         line2_q,       line2_d;
    logic               vis2_q,        vis2_d;
    logic               de2_q,         de2_d;
    logic [11:0]        cell2_q,       cell2_d;

    // Stage 3: glyph selected, font address issued
    logic [3:0]         px3_q,         px3_d;
    logic               vis3_q,        vis3_d;
    logic               de3_q,         de3_d;
    logic [2:0]         colour3_q,     colour3_d;
    logic               hit3_q,        hit3_d;
    logic [11:0]        font_addr_q,   font_addr_d;

    // Stage 4: waiting on the font ROM read
    logic [3:0]         px4_q,         px4_d;
    logic               vis4_q,        vis4_d;
    logic               de4_q,         de4_d;
    logic [2:0]         colour4_q,     colour4_d;
    logic               hit4_q,        hit4_d;

    // Stage 5: registered outputs
    logic [23:0]        vga_data_q,    vga_data_d;
    logic               pix_valid_q,   pix_valid_d;

    // Cursor blink timebase
    logic [BLINK_W-1:0] blink_cnt_q,   blink_cnt_d;
    logic               blink_phase_q, blink_phase_d;

    // Combinational temporaries
    logic [5:0]         row;
    logic [7:0]         glyph;
    logic               lit;
    logic [23:0]        palette;

    // Next-state logic for every pipeline stage. The column tracker steps
    // px/col incrementally while h_addr advances by one each cycle, and
    // clears at h_addr == 0. When the scan position jumps (first pixel after
    // reset, or any non-consecutive h_addr) it resynchronises from the
    // arithmetic definition so the cell position is never stale.
    always_comb begin
        row           = 6'(v_addr >> LINE_W);
        glyph         = 8'd0;
        lit           = 1'b0;
        palette       = 24'hffffff;

        last_h_d      = h_addr;
        track_ok_d    = 1'b1;
        col_d         = col_q;
        px1_d         = px1_q;

        if (h_addr == 10'd0) begin
            px1_d = 4'd0;
            col_d = 7'd0;
        end else if (track_ok_q && (h_addr == last_h_q + 10'd1)) begin
            if (px1_q == PX_LAST) begin
                px1_d = 4'd0;
                col_d = col_q + 7'd1;
            end else begin
                px1_d = px1_q + 4'd1;
            end
        end else begin
            px1_d = 4'(h_addr % 10'(CELL_W));
            col_d = 7'(h_addr / 10'(CELL_W));
        end

        line1_d       = v_addr[LINE_W-1:0];
        vis1_d        = de && (h_addr < 10'(ACTIVE_W)) && (v_addr < V_LIMIT);
        de1_d         = de;
        vram_addr_d   = 12'(row) * 12'(COLS) + 12'(col_d);

        px2_d         = px1_q;
        line2_d       = line1_q;
        vis2_d        = vis1_q;
        de2_d         = de1_q;
        cell2_d       = vram_addr_q;

        // vram_q / splash_q now hold the data for cell2_q
        glyph         = splash ? splash_q : vram_q[7:0];
        colour3_d     = splash ? 3'd0 : vram_q[10:8];
        font_addr_d   = {glyph, line2_q};
        hit3_d        = cursor_en && blink_phase_q && (cell2_q == cursor_pos);
        px3_d         = px2_q;
        vis3_d        = vis2_q;
        de3_d         = de2_q;

        px4_d         = px3_q;
        vis4_d        = vis3_q;
        de4_d         = de3_q;
        colour4_d     = colour3_q;
        hit4_d        = hit3_q;

        // font_q now holds the glyph row for the stage-4 pixel
        lit           = font_q[px4_q] ^ hit4_q;
        case (colour4_q)
            3'd1:    palette = 24'heefe25;
            3'd2:    palette = 24'h10feee;
            3'd3:    palette = 24'he864d5;
            3'd4:    palette = 24'h38f722;
            3'd5:    palette = 24'hee2d1b;
            default: palette = 24'hffffff;
        endcase
        vga_data_d    = (vis4_q && lit) ? palette : 24'h000000;
        pix_valid_d   = de4_q;

        // Blink counter runs continuously, independent of de
        if (blink_cnt_q == BLINK_W'(BLINK_CYCLES - 1)) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end else begin
            blink_cnt_d   = blink_cnt_q + BLINK_W'(1);
            blink_phase_d = blink_phase_q;
        end
    end

    // All state registers. Reset clears every stage so that a reset in the
    // middle of a line drops all in-flight pixels and the pipeline refills
    // from scratch.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_h_q      <= '0;
            track_ok_q    <= 1'b0;
            col_q         <= '0;
            px1_q         <= '0;
            line1_q       <= '0;
            vis1_q        <= 1'b0;
            de1_q         <= 1'b0;
            vram_addr_q   <= '0;
            px2_q         <= '0;
            line2_q       <= '0;
            vis2_q        <= 1'b0;
            de2_q         <= 1'b0;
            cell2_q       <= '0;
            px3_q         <= '0;
            vis3_q        <= 1'b0;
            de3_q         <= 1'b0;
            colour3_q     <= '0;
            hit3_q        <= 1'b0;
            font_addr_q   <= '0;
            px4_q         <= '0;
            vis4_q        <= 1'b0;
            de4_q         <= 1'b0;
            colour4_q     <= '0;
            hit4_q        <= 1'b0;
            vga_data_q    <= '0;
            pix_valid_q   <= 1'b0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            last_h_q      <= last_h_d;
            track_ok_q    <= track_ok_d;
            col_q         <= col_d;
            px1_q         <= px1_d;
            line1_q       <= line1_d;
            vis1_q        <= vis1_d;
            de1_q         <= de1_d;
            vram_addr_q   <= vram_addr_d;
            px2_q         <= px2_d;
            line2_q       <= line2_d;
            vis2_q        <= vis2_d;
            de2_q         <= de2_d;
            cell2_q       <= cell2_d;
            px3_q         <= px3_d;
            vis3_q        <= vis3_d;
            de3_q         <= de3_d;
            colour3_q     <= colour3_d;
            hit3_q        <= hit3_d;
            font_addr_q   <= font_addr_d;
            px4_q         <= px4_d;
            vis4_q        <= vis4_d;
            de4_q         <= de4_d;
            colour4_q     <= colour4_d;
            hit4_q        <= hit4_d;
            vga_data_q    <= vga_data_d;
            pix_valid_q   <= pix_valid_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    assign vram_addr = vram_addr_q;
    assign font_addr = font_addr_q;
    assign vga_data  = vga_data_q;
    assign pix_valid = pix_valid_q;

endmodule
